// File: rtl/shift_seq8_pkg.sv
// Shared definitions for the shift_seq8 command sequencer.
//
// Holds the shifter op encodings (these match the shifter's next-state
// decode exactly), the command kind codes, the sequencer state codes, the
// packed command record stored in the FIFO and two small helpers used by
// the sequencer FSM.
package shift_seq8_pkg;

  localparam int DATA_W    = 8;
  localparam int AMT_W     = 3;
  localparam int SHAMT_W   = 2;
  localparam int KIND_W    = 2;
  localparam int CMD_W     = KIND_W + AMT_W + DATA_W;
  localparam int SHAMT_MAX = 3;

  // Shifter operation codes
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } op_e;

  // Command kind codes as presented on cmd_kind
  typedef enum logic [1:0] {
    KIND_LSL  = 2'b00,
    KIND_LSR  = 2'b01,
    KIND_ASR  = 2'b10,
    KIND_LOAD = 2'b11
  } kind_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_CAP   = 2'b11
  } state_e;

  // One buffered command; packing order matches {kind, amt, data}
  typedef struct packed {
    kind_e             kind;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Largest step the 2-bit shamt can express without exceeding what is left
  function automatic logic [SHAMT_W-1:0] shift_chunk(input logic [AMT_W-1:0] rem);
    logic [SHAMT_W-1:0] c;
    if (rem > AMT_W'(SHAMT_MAX)) c = SHAMT_W'(SHAMT_MAX);
    else                         c = rem[SHAMT_W-1:0];
    return c;
  endfunction

  // Shifter op that performs one step of the given command kind
  function automatic op_e kind_to_op(input kind_e k);
    op_e o;
    case (k)
      KIND_LSL: o = OP_LSL;
      KIND_LSR: o = OP_LSR;
      KIND_ASR: o = OP_ASR;
      default:  o = OP_NOP;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/shift_seq8_fifo.sv
// shift_cmd_fifo: synchronous command FIFO for the shift sequencer.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset (pointers only)
//   wr_en    in   write request; ignored while full
//   rd_en    in   read request; ignored while empty
//   wr_data  in   W-bit entry to store
//   rd_data  out  head entry, valid combinationally while !empty
//   full     out  no free entry
//   empty    out  no stored entry
//
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter.
module shift_cmd_fifo
  import shift_seq8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_wr;
  logic         w_do_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is data only; stale entries are never visible because empty
  // is derived from the (reset) pointers.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/shift_seq8.sv
// shift_seq8: command sequencer driving an 8-bit shifter.
//
// Accepts {kind, amt, data} commands over valid/ready, buffers them in a
// DEPTH-entry FIFO and runs each one as a LOAD followed by up to three
// shift steps of at most 3 positions each. When the last step has landed
// in the shifter, its d_out is captured and presented with a one-cycle
// res_valid strobe.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept (not full)
//   cmd_kind   in   00 LSL, 01 LSR, 10 ASR, 11 load-only
//   cmd_amt    in   total shift amount 0..7
//   cmd_data   in   operand to load
//   op         out  shifter op (registered)
//   shamt      out  shifter shift amount (registered)
//   d_in       out  shifter load data (registered)
//   d_out      in   shifter register output
//   res_valid  out  one-cycle result strobe (registered)
//   res_data   out  captured result, held until the next strobe
//   busy       out  command in flight or queued
module shift_seq8
  import shift_seq8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [KIND_W-1:0]   cmd_kind,
  input  logic [AMT_W-1:0]    cmd_amt,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic [2:0]          op,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [DATA_W-1:0]   d_in,
  input  logic [DATA_W-1:0]   d_out,
  output logic                res_valid,
  output logic [DATA_W-1:0]   res_data,
  output logic                busy
);

  logic [CMD_W-1:0]   w_wr_data;
  logic [CMD_W-1:0]   w_rd_data;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  cmd_t               w_head;
  logic [SHAMT_W-1:0] w_chunk;

  state_e             r_state;
  op_e                r_op;
  logic [SHAMT_W-1:0] r_shamt;
  logic [DATA_W-1:0]  r_d_in;
  logic [AMT_W-1:0]   r_rem;
  kind_e              r_kind;
  logic               r_res_valid;
  logic [DATA_W-1:0]  r_res_data;

  assign w_wr_data = {cmd_kind, cmd_amt, cmd_data};
  assign w_push    = cmd_valid && !w_full;
  // Pops only from IDLE, and only what was already stored: no bypass path.
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_head    = cmd_t'(w_rd_data);
  assign w_chunk   = shift_chunk(r_rem);

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_push),
    .rd_en   (w_pop),
    .wr_data (w_wr_data),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_shamt     <= '0;
      r_d_in      <= '0;
      r_rem       <= '0;
      r_kind      <= KIND_LSL;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Holding NOP keeps the shifter cleared while nothing runs.
          r_op    <= OP_NOP;
          r_shamt <= '0;
          if (w_pop) begin
            r_op    <= OP_LOAD;
            r_d_in  <= w_head.data;
            r_rem   <= (w_head.kind == KIND_LOAD) ? '0 : w_head.amt;
            r_kind  <= w_head.kind;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD, ST_SHIFT: begin
          if (r_rem == '0) begin
            r_op    <= OP_NOP;
            r_shamt <= '0;
            r_state <= ST_CAP;
          end else begin
            r_op    <= kind_to_op(r_kind);
            r_shamt <= w_chunk;
            r_rem   <= r_rem - {1'b0, w_chunk};
            r_state <= ST_SHIFT;
          end
        end
        ST_CAP: begin
          // d_out now holds the final value; the NOP already issued clears
          // the shifter at this same edge, after we have sampled it.
          r_res_data  <= d_out;
          r_res_valid <= 1'b1;
          r_op        <= OP_NOP;
          r_shamt     <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_op    <= OP_NOP;
          r_shamt <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign op        = r_op;
  assign shamt     = r_shamt;
  assign d_in      = r_d_in;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign cmd_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_shift_seq8.sv
// Bench for shift_seq8 together with a behavioural 8-bit shifter.
// Stimulus pushes expected results into a queue; a monitor pops and compares
// on every res_valid strobe.
module tb_shift_seq8;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       res_valid;
  logic [7:0] res_data;
  logic       busy;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       prev_rv = 1'b0;

  shift_seq8 #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_amt   (cmd_amt),
    .cmd_data  (cmd_data),
    .op        (op),
    .shamt     (shamt),
    .d_in      (d_in),
    .d_out     (d_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shifter: NOP clears, LOAD takes d_in, shifts act on d_out.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_out <= 8'h00;
    else begin
      case (op)
        3'b000:  d_out <= 8'h00;
        3'b001:  d_out <= d_in;
        3'b010:  d_out <= d_out << shamt;
        3'b011:  d_out <= d_out >> shamt;
        3'b100:  d_out <= $unsigned($signed(d_out) >>> shamt);
        default: d_out <= d_out;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%0h required=none", res_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("res_data", {24'h0, res_data}, {24'h0, mon_exp});
      end
      check("pulse_width", {31'h0, prev_rv}, 32'h0);
    end
    prev_rv = res_valid;
  end

  // Leaves cmd_valid high; returns the number of cycles spent stalled.
  task automatic push(input logic [1:0] k, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] e, output int waits);
    bit ok;
    bit rdy;
    ok    = 1'b0;
    waits = 0;
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_amt   = a;
    cmd_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) check("push_timeout", 32'h0, 32'h1);
    #1;
  endtask

  task automatic drain(input int budget, input bit chk_busy);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
      if (chk_busy) check("busy_burst", {31'h0, busy}, 32'h1);
    end
    check("drain", exp_q.size(), 32'h0);
  endtask

  // Single command from idle with a cycle-by-cycle trace check.
  task automatic run_single(input string nm, input logic [1:0] k, input logic [2:0] a,
                            input logic [7:0] d, input logic [7:0] e, input int n,
                            input logic [5:0] sh, input logic [2:0] sop);
    check({nm, "_ready"}, {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_amt   = a;
    cmd_data  = d;
    @(posedge clk);
    exp_q.push_back(e);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check({nm, "_nobypass_op"}, {29'h0, op}, 32'h0);
    check({nm, "_busy"}, {31'h0, busy}, 32'h1);
    @(negedge clk);
    check({nm, "_load_op"}, {29'h0, op}, 32'h1);
    check({nm, "_load_din"}, {24'h0, d_in}, {24'h0, d});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({nm, "_step_op"}, {29'h0, op}, {29'h0, sop});
      check({nm, "_step_shamt"}, {30'h0, shamt}, {30'h0, sh[2*i +: 2]});
    end
    @(negedge clk);
    check({nm, "_cap_op"}, {29'h0, op}, 32'h0);
    check({nm, "_cap_rv"}, {31'h0, res_valid}, 32'h0);
    @(negedge clk);
    check({nm, "_latency_rv"}, {31'h0, res_valid}, 32'h1);
    @(negedge clk);
    check({nm, "_rv_low"}, {31'h0, res_valid}, 32'h0);
    check({nm, "_res_hold"}, {24'h0, res_data}, {24'h0, e});
    check({nm, "_din_hold"}, {24'h0, d_in}, {24'h0, d});
    check({nm, "_idle"}, {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit seen;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind  = 2'b00;
    cmd_amt   = 3'd0;
    cmd_data  = 8'h00;
    #1;
    check("rst_op", {29'h0, op}, 32'h0);
    check("rst_shamt", {30'h0, shamt}, 32'h0);
    check("rst_din", {24'h0, d_in}, 32'h0);
    check("rst_rv", {31'h0, res_valid}, 32'h0);
    check("rst_rd", {24'h0, res_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ready", {31'h0, cmd_ready}, 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single commands: {shamt3,shamt2,shamt1} packed low-first
    run_single("lsl81", 2'b00, 3'd5, 8'h81, 8'h20, 2, {2'd0, 2'd2, 2'd3}, 3'b010);
    run_single("lsrF0", 2'b01, 3'd4, 8'hF0, 8'h0F, 2, {2'd0, 2'd1, 2'd3}, 3'b011);
    run_single("asr80", 2'b10, 3'd7, 8'h80, 8'hFF, 3, {2'd1, 2'd3, 2'd3}, 3'b100);
    run_single("lsl5A", 2'b00, 3'd0, 8'h5A, 8'h5A, 0, 6'd0, 3'b010);
    run_single("ldC3", 2'b11, 3'd6, 8'hC3, 8'hC3, 0, 6'd0, 3'b000);

    // Burst with cmd_valid held high: FIFO fills, 6th push must stall
    push(2'b00, 3'd1, 8'h01, 8'h02, w);
    push(2'b01, 3'd3, 8'h80, 8'h10, w);
    push(2'b10, 3'd2, 8'h90, 8'hE4, w);
    push(2'b11, 3'd7, 8'hA5, 8'hA5, w);
    push(2'b00, 3'd4, 8'h0F, 8'hF0, w);
    check("burst_full_ready", {31'h0, cmd_ready}, 32'h0);
    check("burst_busy", {31'h0, busy}, 32'h1);
    push(2'b01, 3'd7, 8'hFF, 8'h01, w);
    check("burst_stall_seen", {31'h0, (w > 0)}, 32'h1);
    cmd_valid = 1'b0;
    drain(200, 1'b1);

    // Reset during a shift step with two entries queued
    push(2'b10, 3'd7, 8'h80, 8'hFF, w);
    push(2'b00, 3'd1, 8'h01, 8'h02, w);
    push(2'b01, 3'd1, 8'h80, 8'h40, w);
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (op == 3'b100) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_shift_reached", {31'h0, seen}, 32'h1);
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_op", {29'h0, op}, 32'h0);
    check("mid_rst_shamt", {30'h0, shamt}, 32'h0);
    check("mid_rst_din", {24'h0, d_in}, 32'h0);
    check("mid_rst_rv", {31'h0, res_valid}, 32'h0);
    check("mid_rst_rd", {24'h0, res_data}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_ready", {31'h0, cmd_ready}, 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    check("post_rst_op", {29'h0, op}, 32'h0);
    @(posedge clk);
    #1;
    run_single("post_rst", 2'b01, 3'd2, 8'h44, 8'h11, 1, {2'd0, 2'd0, 2'd2}, 3'b011);

    check("final_queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq8.md
Name: shift_seq8

Overview:
- Command sequencer directly upstream of the 8-bit shifter. It generates the shifter's op, shamt and d_in every cycle.
- Accepts shift commands over a valid/ready interface and buffers them in a small FIFO.
- Runs each command as one LOAD followed by as many shift steps as needed. Shifter shamt is 2 bits, so amounts of 4..7 are split into chunks of at most 3.
- Captures the shifter's registered d_out when the command finishes and presents it as a one-cycle result pulse.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_kind  input  2  00 LSL, 01 LSR, 10 ASR, 11 load-only.
- cmd_amt  input  3  total shift amount, 0..7.
- cmd_data  input  8  operand to load.
- op  output  3  to shifter; NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100.
- shamt  output  2  to shifter.
- d_in  output  8  to shifter.
- d_out  input  8  shifter register output.
- res_valid  output  1  one-cycle result strobe.
- res_data  output  8  captured result; holds its value until the next strobe.
- busy  output  1  high when state != IDLE or FIFO not empty.

Behaviour:
- Reset (async, reset_n=0): state IDLE, FIFO empty, op=NOP, shamt=0, d_in=0, res_valid=0, res_data=0, busy=0, cmd_ready=1.
- op, shamt, d_in, res_valid and res_data are all flop outputs.
- Push: on an edge where cmd_valid && cmd_ready, write {kind, amt, data}. When full, cmd_ready=0 and nothing is written.
- Pop: on an edge where state==IDLE and the FIFO is non-empty.
  - No bypass: an entry pushed into an empty FIFO pops at the following edge at the earliest.
  - Push and pop on the same edge are both legal; the count is unchanged.
- Pop edge P: op<=LOAD, d_in<=data, rem<=(kind==11 ? 0 : amt), kind latched; state goes to LOAD.
- LOAD and SHIFT states, at the end edge of each:
  - If rem==0: op<=NOP, shamt<=0, state goes to CAP.
  - Otherwise: op<=shift op for kind, shamt<=min(rem,3), rem<=rem-min(rem,3), state goes to SHIFT.
- CAP state: d_out holds the final result.
  - End edge: res_data<=d_out, res_valid<=1, state goes to IDLE.
  - The shifter clears at that same edge (NOP loads 0). This is expected; the sequencer has already sampled the old value.
- res_valid is high for exactly one cycle. There is no backpressure; the consumer must sample it.
- Latency: res_valid is high in the cycle after edge P+2+N, where N=ceil(amt/3) (0, 1, 2 or 3).
  - Back-to-back commands: the next pop can occur at that same edge (CAP→IDLE, pop on the following edge).
- IDLE drives op=NOP (shifter held at 0). d_in keeps its last value.
- Reset mid-command: the command and all queued entries are discarded and the outputs return to their reset values immediately.
- In-flight commands are unaffected by cmd_valid or FIFO activity.
- Defaults: unreachable state goes to IDLE with op=NOP; all cases fully specified, no latches.

Decomposition:
- Shared header/package: op encodings (NOP, LOAD, LSL, LSR, ASR), identical to the shifter's next-state decode, plus cmd_kind codes and state codes IDLE/LOAD/SHIFT/CAP.
- Sub-module shift_cmd_fifo: synchronous FIFO, DEPTH x 13 bits, async active-low reset.
  - Ports: clk, reset_n, wr_en, rd_en, wr_data, rd_data, full, empty.
  - rd_data is valid combinationally while !empty.
- The top holds the FSM, the rem counter and the output registers.

Test Plan (bench instantiates shift_seq8 with the real 8-bit shifter):
- LSL, data 8'h81, amt 5 → shamt sequence 3 then 2; res_data 8'h20; res_valid 4 cycles after pop edge; single-cycle pulse.
- LSR, data 8'hF0, amt 4 → 8'h0F. ASR, data 8'h80, amt 7 → shamt 3,3,1, result 8'hFF. LSL, data 8'h5A, amt 0 → 8'h5A with N=0.
- Kind 11, data 8'hC3, amt 6 → no shift steps; res_data 8'hC3.
- Push 5 commands back-to-back with cmd_valid held high, DEPTH=4 → cmd_ready drops after the 4th buffered entry and re-rises after the first pop; all 5 results arrive in order; busy stays high throughout.
- Reset_n pulsed low during a SHIFT step with 2 entries queued → outputs go to reset values asynchronously; no res_valid; FIFO empty; cmd_ready=1.
- Push into an empty FIFO while IDLE → LOAD appears on op one edge after the push edge (no bypass); simultaneous push and pop leaves the count unchanged.
